bcd_time_counter: RTL
=====================

// Module: bcd_time_counter
// PURPOSE
//   Parametrised successor to the HH:MM clock counter. BCD hours:minutes, selectable 24h/12h mode,
//   tick prescaler, validated time-load handshake, day-rollover pulse. Sits between the board tick
//   source and the 7-segment display driver.
// PARAMETERS
//   DIV      1   tick pulses per minute advance (1..65535); internal prescaler width = $clog2(DIV+1)
//   HR_MODE  24  24 = 00:00..23:59; 12 = 12:00..11:59 with pm flag
// PORTS
//   clk        in   1  single clock; all state updates on posedge clk
//   reset      in   1  synchronous, active-high; overrides every other input
//   tick       in   1  one-cycle advance strobe; prescaled by DIV
//   load_valid in   1  request to load the time on ld_* (sampled when load_ready=1)
//   load_ready out  1  1 whenever reset=0; 0 during reset
//   ld_hr_tens in   2  load value, hour tens digit
//   ld_hr_units in  4  load value, hour units digit
//   ld_min_tens in  3  load value, minute tens digit
//   ld_min_units in 4  load value, minute units digit
//   ld_pm      in   1  load value, pm flag (ignored when HR_MODE=24)
//   load_err   out  1  one-cycle pulse: previous-cycle load rejected
//   hr_tens    out  2  hour tens digit
//   hr_units   out  4  hour units digit
//   min_tens   out  3  minute tens digit
//   min_units  out  4  minute units digit
//   pm         out  1  12h mode PM flag; constant 0 when HR_MODE=24
//   day_carry  out  1  one-cycle pulse on midnight rollover
// BEHAVIOUR
//   Reset: 24h -> 00:00, 12h -> 12:00 with pm=0; prescaler=0; load_err=0, day_carry=0.
//   Priority per cycle: reset > accepted load > tick advance.
//   Prescaler: each tick increments it; on the DIV-th tick it clears and time advances by one
//     minute. All outputs are registered: new time visible the cycle after the advancing tick.
//   Advance: min_units 9->0 carries into min_tens; min_tens 5->0 carries into hours.
//     24h: 09->10, 19->20, 23:59 -> 00:00 with day_carry=1.
//     12h: 12->01, 09->10, 11:59 -> 12:00 toggles pm; day_carry=1 only on the PM->AM toggle.
//   Load: accepted when load_valid and load_ready. Valid: min_units<=9, min_tens<=5, hour in
//     00..23 (24h) or 01..12 (12h). Valid load: digits and pm register next cycle, prescaler
//     clears, any same-cycle tick is dropped. Invalid load: time unchanged, load_err=1 next
//     cycle, prescaler continues; a same-cycle tick is still counted. No day_carry on load.
//   Back-to-back loads are accepted every cycle; the last valid load wins.
//   A tick arriving when tick is held high counts once per cycle (level = one tick per clk).
// CONFIGURATION
//   BCD_TIME_ALARM_EN defined: adds ports alarm_set (in,1) plus al_hr_tens/al_hr_units/
//     al_min_tens/al_min_units/al_pm (in, same widths as ld_*) and alarm_hit (out,1).
//     alarm_set latches the alarm time (same validation rule; invalid -> load_err).
//     alarm_hit pulses one cycle when an advance makes time equal the alarm; a load never
//     fires alarm_hit. Alarm register resets to disabled (no hit until first valid alarm_set).
//   Not defined: the alarm ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//   Shared package time_pkg: bcd_digit_t (4-bit), HR_MODE_12/HR_MODE_24 constants,
//     MIN_TENS_MAX=5, BCD_MAX=9, time_t struct {hr_tens, hr_units, min_tens, min_units, pm},
//     function time_valid(time_t, mode).
//   Sub-module bcd_digit_counter #(MAX): one digit, inc/clear/load inputs, wraps MAX->0,
//     carry_out when at MAX and inc. Used for both minute digits; hours in a dedicated
//     two-digit block because the wrap depends on the tens digit and on HR_MODE.
// TESTING
//   DIV=1, 24h: reset, load 23:58, 2 ticks -> 23:59 then 00:00, day_carry high exactly 1 cycle.
//   DIV=4, 24h: reset, 7 ticks -> 00:01; 1 more tick -> 00:02 (prescaler resets on advance).
//   12h: load 11:59 pm=0, tick -> 12:00 pm=1, no day_carry; load 11:59 pm=1, tick -> 12:00
//     pm=0 with day_carry=1; load 12:59, tick -> 01:00.
//   Invalid loads: 24:00, 07:60, 00:0A (24h) and 00:30 (12h) -> time unchanged, load_err 1 cycle.
//   Load of 10:15 in the same cycle as an advancing tick -> 10:15, no advance; reset asserted
//     with load_valid and tick -> reset value, load_ready=0.
//   BCD_TIME_ALARM_EN: alarm 06:30, load 06:29, tick -> alarm_hit 1 cycle; load 06:30 -> no hit.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types and helpers for the BCD time-of-day counter.
//   bcd_digit_t : 4-bit BCD digit
//   time_t      : packed HH:MM + pm payload
//   time_valid  : range check of a candidate time for the given hour mode
package time_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned HR_MODE_12   = 12;
   localparam int unsigned HR_MODE_24   = 24;
   localparam int unsigned MIN_TENS_MAX = 5;
   localparam int unsigned BCD_MAX      = 9;

   typedef struct packed {
      logic [1:0] hr_tens;
      bcd_digit_t hr_units;
      logic [2:0] min_tens;
      bcd_digit_t min_units;
      logic       pm;
   } time_t;

   // Digits must be legal BCD and the hour must sit in the mode's range.
   function automatic logic time_valid(time_t t, int unsigned mode);
      logic       digits_ok;
      logic [5:0] hour;
      digits_ok = (t.min_units <= 4'(BCD_MAX)) &&
                  (t.min_tens  <= 3'(MIN_TENS_MAX)) &&
                  (t.hr_units  <= 4'(BCD_MAX));
      hour = 6'(t.hr_tens) * 6'd10 + 6'(t.hr_units);
      if (mode == HR_MODE_12) begin
         return digits_ok && (hour >= 6'd1) && (hour <= 6'd12);
      end
      return digits_ok && (hour <= 6'd23);
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single wrapping digit counter.
//   clk       : clock
//   clear     : synchronous clear to 0 (highest priority)
//   inc       : advance by one, wrapping MAX -> 0
//   load      : load load_val (beats inc)
//   load_val  : value for load
//   q         : registered digit
//   carry_out : combinational, high when q == MAX and inc
module bcd_digit_counter #(
   parameter int unsigned W   = 4,
   parameter int unsigned MAX = 9
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q,
   output logic         carry_out
);

   assign carry_out = inc && (q == W'(MAX));

   // Digit register: clear > load > inc
   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (inc) begin
         q <= carry_out ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD HH:MM time-of-day counter with tick prescaler, validated load and
// midnight rollover pulse. Optional alarm enabled by macro BCD_TIME_ALARM_EN.
//   clk, reset          : clock, synchronous active-high reset
//   tick                : advance strobe, one minute per DIV ticks
//   load_valid/ready    : time-load handshake (ld_* digits, ld_pm)
//   load_err            : pulse, previous-cycle load (or alarm set) rejected
//   hr_*, min_*, pm     : current time
//   day_carry           : pulse on midnight rollover
//   alarm_set, al_*     : (alarm build) latch alarm time
//   alarm_hit           : (alarm build) pulse when an advance reaches the alarm
module bcd_time_counter
   import time_pkg::*;
#(
   parameter int unsigned DIV     = 1,
   parameter int unsigned HR_MODE = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [1:0] ld_hr_tens,
   input  logic [3:0] ld_hr_units,
   input  logic [2:0] ld_min_tens,
   input  logic [3:0] ld_min_units,
   input  logic       ld_pm,
   output logic       load_err,
   output logic [1:0] hr_tens,
   output logic [3:0] hr_units,
   output logic [2:0] min_tens,
   output logic [3:0] min_units,
   output logic       pm,
   output logic       day_carry
`ifdef BCD_TIME_ALARM_EN
   ,
   input  logic       alarm_set,
   input  logic [1:0] al_hr_tens,
   input  logic [3:0] al_hr_units,
   input  logic [2:0] al_min_tens,
   input  logic [3:0] al_min_units,
   input  logic       al_pm,
   output logic       alarm_hit
`endif
);

   localparam int unsigned PW     = $clog2(DIV + 1);
   localparam bit          IS12   = (HR_MODE == HR_MODE_12);
   localparam logic [1:0]  HT_RST = IS12 ? 2'd1 : 2'd0;
   localparam logic [3:0]  HU_RST = IS12 ? 4'd2 : 4'd0;

   time_t         ld_t;
   logic          load_acc, load_ok, load_bad, err_c;
   logic          tick_eff, presc_hit, adv;
   logic [PW-1:0] presc;
   logic          mu_carry, mt_carry, hr_adv;
   logic [1:0]    hr_tens_n;
   logic [3:0]    hr_units_n;
   logic          pm_n, roll_c;

   // Ready follows reset directly so a request is never dropped outside reset.
   assign load_ready = ~reset;

   // Load candidate; pm is meaningless in 24h mode and forced low.
   always_comb begin
      ld_t.hr_tens   = ld_hr_tens;
      ld_t.hr_units  = ld_hr_units;
      ld_t.min_tens  = ld_min_tens;
      ld_t.min_units = ld_min_units;
      ld_t.pm        = IS12 ? ld_pm : 1'b0;
   end

   assign load_acc = load_valid & ~reset;
   assign load_ok  = load_acc & time_valid(ld_t, HR_MODE);
   assign load_bad = load_acc & ~time_valid(ld_t, HR_MODE);

   // A valid load swallows any same-cycle tick; an invalid one does not.
   assign tick_eff  = tick & ~reset & ~load_ok;
   assign presc_hit = (presc == PW'(DIV - 1));
   assign adv       = tick_eff & presc_hit;

   // Tick prescaler
   always_ff @(posedge clk) begin
      if (reset || load_ok) begin
         presc <= '0;
      end else if (tick_eff) begin
         presc <= presc_hit ? '0 : presc + PW'(1);
      end
   end

   // Minute digits
   bcd_digit_counter #(.W(4), .MAX(BCD_MAX)) u_min_units (
      .clk       (clk),
      .clear     (reset),
      .inc       (adv),
      .load      (load_ok),
      .load_val  (ld_min_units),
      .q         (min_units),
      .carry_out (mu_carry)
   );

   bcd_digit_counter #(.W(3), .MAX(MIN_TENS_MAX)) u_min_tens (
      .clk       (clk),
      .clear     (reset),
      .inc       (mu_carry),
      .load      (load_ok),
      .load_val  (ld_min_tens),
      .q         (min_tens),
      .carry_out (mt_carry)
   );

   assign hr_adv = mt_carry;

   // Hour pair next value; wrap depends on the tens digit and the mode.
   always_comb begin
      hr_tens_n  = hr_tens;
      hr_units_n = hr_units;
      pm_n       = pm;
      roll_c     = 1'b0;
      if (load_ok) begin
         hr_tens_n  = ld_t.hr_tens;
         hr_units_n = ld_t.hr_units;
         pm_n       = ld_t.pm;
      end else if (hr_adv) begin
         if (IS12) begin
            if (hr_tens == 2'd1 && hr_units == 4'd2) begin
               hr_tens_n  = 2'd0;
               hr_units_n = 4'd1;
            end else if (hr_tens == 2'd1 && hr_units == 4'd1) begin
               // 11:59 -> 12:00 flips the half-day; only PM->AM ends the day
               hr_units_n = 4'd2;
               pm_n       = ~pm;
               roll_c     = pm;
            end else if (hr_units == 4'(BCD_MAX)) begin
               hr_tens_n  = hr_tens + 2'd1;
               hr_units_n = 4'd0;
            end else begin
               hr_units_n = hr_units + 4'd1;
            end
         end else begin
            if (hr_tens == 2'd2 && hr_units == 4'd3) begin
               hr_tens_n  = 2'd0;
               hr_units_n = 4'd0;
               roll_c     = 1'b1;
            end else if (hr_units == 4'(BCD_MAX)) begin
               hr_tens_n  = hr_tens + 2'd1;
               hr_units_n = 4'd0;
            end else begin
               hr_units_n = hr_units + 4'd1;
            end
         end
      end
   end

   // Hour, pm and status pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         hr_tens   <= HT_RST;
         hr_units  <= HU_RST;
         pm        <= 1'b0;
         day_carry <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         hr_tens   <= hr_tens_n;
         hr_units  <= hr_units_n;
         pm        <= pm_n;
         day_carry <= roll_c;
         load_err  <= err_c;
      end
   end

`ifdef BCD_TIME_ALARM_EN
   time_t al_t, al_q, nxt_t;
   logic  al_en, al_ok, al_bad;

   // Alarm candidate and the time an advance would produce this cycle
   always_comb begin
      al_t.hr_tens    = al_hr_tens;
      al_t.hr_units   = al_hr_units;
      al_t.min_tens   = al_min_tens;
      al_t.min_units  = al_min_units;
      al_t.pm         = IS12 ? al_pm : 1'b0;
      nxt_t.hr_tens   = hr_tens_n;
      nxt_t.hr_units  = hr_units_n;
      nxt_t.min_tens  = mt_carry ? 3'd0 : (mu_carry ? min_tens + 3'd1 : min_tens);
      nxt_t.min_units = mu_carry ? 4'd0 : min_units + 4'd1;
      nxt_t.pm        = pm_n;
   end

   assign al_ok  = alarm_set & ~reset & time_valid(al_t, HR_MODE);
   assign al_bad = alarm_set & ~reset & ~time_valid(al_t, HR_MODE);
   assign err_c  = load_bad | al_bad;

   // Alarm register; compares against the alarm held before this cycle's set
   always_ff @(posedge clk) begin
      if (reset) begin
         al_en     <= 1'b0;
         al_q      <= '0;
         alarm_hit <= 1'b0;
      end else begin
         alarm_hit <= adv & al_en & (nxt_t == al_q);
         if (al_ok) begin
            al_q  <= al_t;
            al_en <= 1'b1;
         end
      end
   end
`else
   assign err_c = load_bad;
`endif

endmodule
